stat_display_reader: RTL and testbench

- Reads the four 25-bit performance counters exported by the PC unit: total cycles, unconditional jumps, conditional jumps and successful conditional jumps.
- Converts the selected counter to 8 BCD digits with a sequential double-dabble engine.
- Drives the board's 8-digit multiplexed 7-segment display.
- Sits at the top level between the PC unit's statistics outputs and the display pins.

---
 rtl/stat_display_reader.sv | 163 ++++++++++++++++
 tb/tb_stat_display_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_display_reader.sv
// Samples one of four PC-unit performance counters, converts it to 8 BCD digits
// with a sequential double-dabble engine and scans them onto a 7-segment display.
`timescale 1ns/1ps
module stat_display_reader #(
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int SCAN_DIV      = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  select,
  input  logic [24:0] totalCycle,
  input  logic [24:0] unconditionalJump,
  input  logic [24:0] conditionalJump,
  input  logic [24:0] conditionalSuccessfulJump,
  output logic [7:0]  anode,
  output logic [7:0]  segment,
  output logic        busy,
  output logic        updated
);

  localparam int SCW = $clog2(SAMPLE_PERIOD);
  localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_PERIOD - 1);
  localparam logic [DVW-1:0] SCAN_LAST   = DVW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

  state_t          state_q;
  logic [24:0]     shift_q;
  logic [31:0]     bcd_q;
  logic [4:0]      step_q;
  logic            pending_q;
  logic [1:0]      sel_prev_q;
  logic [SCW-1:0]  sample_cnt_q;
  logic [31:0]     digits_q;
  logic            busy_q;
  logic            updated_q;
  logic [DVW-1:0]  scan_div_q;
  logic [2:0]      scan_idx_q;
  logic [7:0]      anode_q;
  logic [7:0]      segment_q;

  logic            tick;
  logic            start_req;
  logic [24:0]     picked;
  logic [31:0]     bcd_adj;
  logic [3:0]      cur_digit;
  logic [31:0]     upper_digits;
  logic            blank;
  logic [7:0]      segment_d;

  always_comb begin
    tick      = (sample_cnt_q == SAMPLE_LAST);
    start_req = tick | (select != sel_prev_q) | pending_q;
    picked    = totalCycle;
    case (select)
      2'd0:    picked = totalCycle;
      2'd1:    picked = unconditionalJump;
      2'd2:    picked = conditionalJump;
      default: picked = conditionalSuccessfulJump;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bcd_q        <= '0;
      step_q       <= '0;
      pending_q    <= 1'b0;
      sel_prev_q   <= '0;
      sample_cnt_q <= '0;
      digits_q     <= '0;
      busy_q       <= 1'b0;
      updated_q    <= 1'b0;
    end else begin
      sel_prev_q   <= select;
      sample_cnt_q <= tick ? '0 : sample_cnt_q + SCW'(1);
      updated_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_req) begin
            shift_q   <= picked;
            bcd_q     <= '0;
            step_q    <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CONVERT;
          end
        end
        CONVERT: begin
          if (start_req) pending_q <= 1'b1;
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          step_q <= step_q + 5'd1;
          if (step_q == 5'd24) state_q <= LATCH;
        end
        LATCH: begin
          if (start_req) pending_q <= 1'b1;
          digits_q  <= bcd_q;
          updated_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A digit above position 0 is blanked when it and every higher digit are zero.
  always_comb begin
    cur_digit    = digits_q[{scan_idx_q, 2'b00} +: 4];
    upper_digits = digits_q >> {scan_idx_q, 2'b00};
    blank        = (scan_idx_q != 3'd0) && (upper_digits == '0);
    segment_d    = 8'hFF;
    if (!blank) begin
      case (cur_digit)
        4'd0:    segment_d = 8'hC0;
        4'd1:    segment_d = 8'hF9;
        4'd2:    segment_d = 8'hA4;
        4'd3:    segment_d = 8'hB0;
        4'd4:    segment_d = 8'h99;
        4'd5:    segment_d = 8'h92;
        4'd6:    segment_d = 8'h82;
        4'd7:    segment_d = 8'hF8;
        4'd8:    segment_d = 8'h80;
        4'd9:    segment_d = 8'h90;
        default: segment_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_div_q <= '0;
      scan_idx_q <= '0;
      anode_q    <= 8'hFE;
      segment_q  <= 8'hC0;
    end else begin
      if (scan_div_q == SCAN_LAST) begin
        scan_div_q <= '0;
        scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
        scan_div_q <= scan_div_q + DVW'(1);
      end
      anode_q   <= ~(8'h01 << scan_idx_q);
      segment_q <= segment_d;
    end
  end

  assign anode   = anode_q;
  assign segment = segment_q;
  assign busy    = busy_q;
  assign updated = updated_q;

endmodule

// File: tb/tb_stat_display_reader.sv
// Directed bench for stat_display_reader with SAMPLE_PERIOD=64, SCAN_DIV=4.
`timescale 1ns/1ps
module tb_stat_display_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  select = 2'd0;
  logic [24:0] totalCycle = 25'd12345678;
  logic [24:0] unconditionalJump = 25'd0;
  logic [24:0] conditionalJump = 25'd0;
  logic [24:0] conditionalSuccessfulJump = 25'd33554431;
  logic [7:0]  anode;
  logic [7:0]  segment;
  logic        busy;
  logic        updated;

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [7:0]  seen_seg [8];
  bit          read_ok;

  // Expected segment codes, index 0 = least significant digit.
  logic [7:0] exp_12345678 [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] exp_7        [8] = '{8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] exp_max      [8] = '{8'hF9, 8'hB0, 8'h99, 8'h99, 8'h92, 8'h92, 8'hB0, 8'hB0};
  logic [7:0] exp_5        [8] = '{8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  stat_display_reader #(.SAMPLE_PERIOD(64), .SCAN_DIV(4)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .select                    (select),
    .totalCycle                (totalCycle),
    .unconditionalJump         (unconditionalJump),
    .conditionalJump           (conditionalJump),
    .conditionalSuccessfulJump (conditionalSuccessfulJump),
    .anode                     (anode),
    .segment                   (segment),
    .busy                      (busy),
    .updated                   (updated)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_update(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 120; n++) begin
      if (updated === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic read_digits();
    logic [7:0] mask;
    logic [7:0] oh;
    mask = 8'h00;
    for (int n = 0; n < 48 && mask != 8'hFF; n++) begin
      for (int i = 0; i < 8; i++) begin
        oh = 8'h01 << i;
        if (anode === ~oh) begin
          seen_seg[i] = segment;
          mask[i] = 1'b1;
        end
      end
      if (mask != 8'hFF) step();
    end
    read_ok = (mask == 8'hFF);
  endtask

  task automatic test_reset();
    logic [7:0] oh;
    int idx;
    step();
    step();
    reset = 1'b0;
    checks++; if (anode !== 8'hFE) $display("FAIL reset_anode got=%h exp=fe", anode); else passed++;
    checks++; if (segment !== 8'hC0) $display("FAIL reset_segment got=%h exp=c0", segment); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (updated !== 1'b0) $display("FAIL reset_updated got=%b exp=0", updated); else passed++;
    for (int k = 1; k <= 40; k++) begin
      step();
      idx = ((k - 1) / 4) % 8;
      oh = 8'h01 << idx;
      checks++;
      if (anode !== ~oh) $display("FAIL scan_anode k=%0d got=%h exp=%h", k, anode, ~oh);
      else passed++;
      checks++;
      if (segment !== ((idx == 0) ? 8'hC0 : 8'hFF))
        $display("FAIL scan_segment k=%0d got=%h exp=%h", k, segment, (idx == 0) ? 8'hC0 : 8'hFF);
      else passed++;
    end
  endtask

  task automatic test_periodic_convert();
    bit rose;
    int busy_cycles;
    rose = 1'b0;
    for (int n = 0; n < 100 && !rose; n++) begin
      if (busy === 1'b1) rose = 1'b1;
      else step();
    end
    checks++; if (!rose) $display("FAIL tick_start got=busy_low exp=busy_high"); else passed++;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      step();
    end
    checks++; if (busy_cycles != 26) $display("FAIL busy_width got=%0d exp=26", busy_cycles); else passed++;
    checks++; if (updated !== 1'b1) $display("FAIL update_pulse got=%b exp=1", updated); else passed++;
    step();
    checks++; if (updated !== 1'b0) $display("FAIL update_single got=%b exp=0", updated); else passed++;
    read_digits();
    checks++; if (!read_ok) $display("FAIL t2_read got=incomplete exp=8_digits"); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seen_seg[i] !== exp_12345678[i]) $display("FAIL t2_digit%0d got=%h exp=%h", i, seen_seg[i], exp_12345678[i]);
      else passed++;
    end
  endtask

  task automatic test_select_change();
    bit ok;
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t3_idle_wait got=timeout exp=update"); else passed++;
    conditionalJump = 25'd7;
    select = 2'd2;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL t3_start got=%b exp=1", busy); else passed++;
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t3_update got=timeout exp=update"); else passed++;
    step();
    read_digits();
    checks++; if (!read_ok) $display("FAIL t3_read got=incomplete exp=8_digits"); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seen_seg[i] !== exp_7[i]) $display("FAIL t3_digit%0d got=%h exp=%h", i, seen_seg[i], exp_7[i]);
      else passed++;
    end
  endtask

  task automatic test_queued_select();
    bit ok;
    int idx;
    logic [7:0] oh;
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t4_idle_wait got=timeout exp=update"); else passed++;
    select = 2'd0;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL t4_startA got=%b exp=1", busy); else passed++;
    repeat (5) step();
    select = 2'd3;
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t4_updateA got=timeout exp=update"); else passed++;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL t4_startB got=%b exp=1", busy); else passed++;
    // While the queued conversion runs, the display must show the first result.
    for (int n = 0; n < 25; n++) begin
      idx = -1;
      for (int i = 0; i < 8; i++) begin
        oh = 8'h01 << i;
        if (anode === ~oh) idx = i;
      end
      checks++;
      if (idx < 0) $display("FAIL t4_anode n=%0d got=%h exp=one_low", n, anode);
      else if (segment !== exp_12345678[idx])
        $display("FAIL t4_shownA n=%0d got=%h exp=%h", n, segment, exp_12345678[idx]);
      else passed++;
      step();
    end
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t4_updateB got=timeout exp=update"); else passed++;
    step();
    read_digits();
    checks++; if (!read_ok) $display("FAIL t4_read got=incomplete exp=8_digits"); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seen_seg[i] !== exp_max[i]) $display("FAIL t4_digit%0d got=%h exp=%h", i, seen_seg[i], exp_max[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_convert();
    bit ok;
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t5_idle_wait got=timeout exp=update"); else passed++;
    unconditionalJump = 25'd42;
    select = 2'd1;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL t5_start got=%b exp=1", busy); else passed++;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL t5_busy got=%b exp=0", busy); else passed++;
    checks++; if (updated !== 1'b0) $display("FAIL t5_updated got=%b exp=0", updated); else passed++;
    checks++; if (anode !== 8'hFE) $display("FAIL t5_anode got=%h exp=fe", anode); else passed++;
    checks++; if (segment !== 8'hC0) $display("FAIL t5_segment got=%h exp=c0", segment); else passed++;
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (updated !== 1'b0) $display("FAIL t5_no_pulse n=%0d got=%b exp=0", n, updated);
      else passed++;
      checks++;
      if (segment !== ((anode === 8'hFE) ? 8'hC0 : 8'hFF))
        $display("FAIL t5_zero_display n=%0d got=%h exp=%h", n, segment, (anode === 8'hFE) ? 8'hC0 : 8'hFF);
      else passed++;
    end
  endtask

  task automatic test_sample_once();
    bit ok;
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t6_idle_wait got=timeout exp=update"); else passed++;
    select = 2'd0;
    totalCycle = 25'd5;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL t6_start got=%b exp=1", busy); else passed++;
    totalCycle = 25'd9;
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t6_update got=timeout exp=update"); else passed++;
    step();
    read_digits();
    checks++; if (!read_ok) $display("FAIL t6_read got=incomplete exp=8_digits"); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (seen_seg[i] !== exp_5[i]) $display("FAIL t6_digit%0d got=%h exp=%h", i, seen_seg[i], exp_5[i]);
      else passed++;
    end
    wait_update(ok);
    checks++; if (!ok) $display("FAIL t6_periodic got=timeout exp=update"); else passed++;
    step();
    read_digits();
    checks++; if (!read_ok) $display("FAIL t6_read2 got=incomplete exp=8_digits"); else passed++;
    checks++; if (seen_seg[0] !== 8'h90) $display("FAIL t6_digit0_nine got=%h exp=90", seen_seg[0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_periodic_convert();
    test_select_change();
    test_queued_select();
    test_reset_mid_convert();
    test_sample_once();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
